// File: rtl/cv32e40p_obi_checker.sv
// OBI protocol checker for the cv32e40p instruction/data ports: per-port handshake FSM,
// outstanding counter and wait timers feeding sticky, first-error-coded flags.

module cv32e40p_obi_checker #(
  parameter int unsigned          NUM_PORTS       = 2,
  parameter int unsigned          ADDR_WIDTH      = 32,
  parameter int unsigned          DATA_WIDTH      = 32,
  parameter int unsigned          MAX_OUTSTANDING = 2,
  parameter int unsigned          MAX_GNT_WAIT    = 16,
  parameter int unsigned          MAX_RVALID_WAIT = 32,
  parameter logic [NUM_PORTS-1:0] ASSUME_MASK     = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              gnt_i,
  input  logic [NUM_PORTS-1:0]              rvalid_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS*4-1:0]            outstanding_o,
  output logic [NUM_PORTS-1:0]              err_o,
  output logic [NUM_PORTS*4-1:0]            err_code_o,
  output logic                              err_any_o
);

  localparam int unsigned   BE_WIDTH   = DATA_WIDTH / 8;
  localparam int unsigned   TW         = 16;
  localparam logic [TW-1:0] GNT_LIM    = TW'(MAX_GNT_WAIT);
  localparam logic [TW-1:0] RV_LIM     = TW'(MAX_RVALID_WAIT);
  localparam bit            GNT_CHK_EN = (MAX_GNT_WAIT != 0);
  localparam bit            RV_CHK_EN  = (MAX_RVALID_WAIT != 0);
  localparam logic [3:0]    OUTST_MAX  = 4'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_GNT = 1'b1
  } state_e;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == {TW{1'b1}}) ? v : v + {{(TW-1){1'b0}}, 1'b1};
  endfunction

  // Lowest-numbered violation wins when several fire together.
  function automatic logic [3:0] lowest_code(input logic [7:1] hit);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 7; i >= 1; i--) begin
      code = hit[i] ? 4'(i) : code;
    end
    return code;
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic                  req_s, gnt_s, rvalid_s, we_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [BE_WIDTH-1:0]   be_s;
    logic [DATA_WIDTH-1:0] wdata_s;

    state_e                state_r, state_next_s;
    logic                  we_cap_r;
    logic [ADDR_WIDTH-1:0] addr_cap_r;
    logic [BE_WIDTH-1:0]   be_cap_r;
    logic [DATA_WIDTH-1:0] wdata_cap_r;
    logic [3:0]            outst_r, outst_next_s;
    logic [TW-1:0]         gnt_tmr_r, gnt_tmr_next_s, rv_tmr_r, rv_tmr_next_s;
    logic                  err_r;
    logic [3:0]            code_r;
    logic                  xfer_s, capture_s, gnt_wait_s, rv_wait_s, payload_diff_s;
    logic [7:1]            hit_s;

    assign req_s    = req_i[p];
    assign gnt_s    = gnt_i[p];
    assign rvalid_s = rvalid_i[p];
    assign we_s     = we_i[p];
    assign addr_s   = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign be_s     = be_i[p*BE_WIDTH +: BE_WIDTH];
    assign wdata_s  = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];

    // Next-state, counter/timer updates and per-cycle violation detection.
    always_comb begin
      xfer_s     = req_s & gnt_s;
      capture_s  = (state_r == ST_IDLE) && req_s && !gnt_s;
      gnt_wait_s = !gnt_s && (capture_s || (state_r == ST_WAIT_GNT));
      rv_wait_s  = (outst_r != 4'd0) && !rvalid_s;

      case (state_r)
        ST_IDLE:     state_next_s = capture_s ? ST_WAIT_GNT : ST_IDLE;
        ST_WAIT_GNT: state_next_s = xfer_s ? ST_IDLE : ST_WAIT_GNT;
        default:     state_next_s = ST_IDLE;
      endcase

      case ({xfer_s, rvalid_s})
        2'b10:   outst_next_s = (outst_r == 4'd15) ? outst_r : outst_r + 4'd1;
        2'b01:   outst_next_s = (outst_r == 4'd0) ? outst_r : outst_r - 4'd1;
        default: outst_next_s = outst_r;
      endcase

      // Timers hold the number of earlier consecutive waiting cycles.
      gnt_tmr_next_s = gnt_wait_s ? sat_inc(gnt_tmr_r) : {TW{1'b0}};
      rv_tmr_next_s  = rv_wait_s ? sat_inc(rv_tmr_r) : {TW{1'b0}};

      payload_diff_s = (we_s != we_cap_r) || (addr_s != addr_cap_r) || (be_s != be_cap_r) ||
                       (we_cap_r && (wdata_s != wdata_cap_r));

      hit_s[1] = (state_r == ST_WAIT_GNT) && !req_s;
      hit_s[2] = (state_r == ST_WAIT_GNT) && req_s && payload_diff_s;
      hit_s[3] = rvalid_s && (outst_r == 4'd0);
      hit_s[4] = xfer_s && (outst_r == OUTST_MAX) && !rvalid_s;
      hit_s[5] = GNT_CHK_EN && gnt_wait_s && (gnt_tmr_r >= GNT_LIM);
      hit_s[6] = RV_CHK_EN && rv_wait_s && (rv_tmr_r >= RV_LIM);
      hit_s[7] = req_s && (be_s == {BE_WIDTH{1'b0}});
    end

    // Tracking state, captured payload and sticky first-error record.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_r     <= ST_IDLE;
        we_cap_r    <= 1'b0;
        addr_cap_r  <= {ADDR_WIDTH{1'b0}};
        be_cap_r    <= {BE_WIDTH{1'b0}};
        wdata_cap_r <= {DATA_WIDTH{1'b0}};
        outst_r     <= 4'd0;
        gnt_tmr_r   <= {TW{1'b0}};
        rv_tmr_r    <= {TW{1'b0}};
        err_r       <= 1'b0;
        code_r      <= 4'd0;
      end else begin
        state_r   <= state_next_s;
        outst_r   <= outst_next_s;
        gnt_tmr_r <= gnt_tmr_next_s;
        rv_tmr_r  <= rv_tmr_next_s;
        if (capture_s) begin
          we_cap_r    <= we_s;
          addr_cap_r  <= addr_s;
          be_cap_r    <= be_s;
          wdata_cap_r <= wdata_s;
        end
        if (enable_i && !err_r && (hit_s != 7'd0)) begin
          err_r  <= 1'b1;
          code_r <= lowest_code(hit_s);
        end
      end
    end

    assign outstanding_o[p*4 +: 4] = outst_r;
    assign err_o[p]                = err_r;
    assign err_code_o[p*4 +: 4]    = code_r;

    if (ASSUME_MASK[p]) begin : g_assume
`ifdef FORMAL
      cv32e40p_obi_checker_props #(.ASSUME_RESP(1'b1)) u_props (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .scan_cg_en_i (1'b0),
        .err_i        (err_r),
        .code_i       (code_r)
      );
`endif
    end else begin : g_assert
`ifdef FORMAL
      cv32e40p_obi_checker_props #(.ASSUME_RESP(1'b0)) u_props (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .scan_cg_en_i (1'b0),
        .err_i        (err_r),
        .code_i       (code_r)
      );
`endif
    end
  end

  assign err_any_o = |err_o;

endmodule

`ifdef FORMAL
// Formal binding of one port's flag; responder-side codes 3..6 become assumptions when requested.
module cv32e40p_obi_checker_props #(
  parameter bit ASSUME_RESP = 1'b0
) (
  input logic       clk_i,
  input logic       rst_ni,
  input logic       scan_cg_en_i,
  input logic       err_i,
  input logic [3:0] code_i
);

  logic resp_side_s;
  assign resp_side_s = (code_i >= 4'd3) && (code_i <= 4'd6);

  // Scan is tied off here; a harness may bind the core's scan enable instead.
  assume_no_scan: assume property (@(posedge clk_i) !scan_cg_en_i);

  if (ASSUME_RESP) begin : g_resp_assume
    assume_no_resp_err: assume property (@(posedge clk_i) disable iff (!rst_ni) !(err_i && resp_side_s));
    assert_no_mgr_err:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(err_i && !resp_side_s));
  end else begin : g_all_assert
    assert_no_err: assert property (@(posedge clk_i) disable iff (!rst_ni) !err_i);
  end

endmodule
`endif

// File: tb/tb_cv32e40p_obi_checker.sv
// Directed bench for cv32e40p_obi_checker: a per-cycle vector table plus hand-written
// sequences for timeout, enable masking and asynchronous reset corner cases.

module tb_cv32e40p_obi_checker;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [1:0]  req_i, gnt_i, rvalid_i, we_i;
  logic [63:0] addr_i;
  logic [7:0]  be_i;
  logic [63:0] wdata_i;
  logic [7:0]  outstanding_o;
  logic [1:0]  err_o;
  logic [7:0]  err_code_o;
  logic        err_any_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  cv32e40p_obi_checker #(
    .NUM_PORTS       (2),
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2),
    .MAX_GNT_WAIT    (16),
    .MAX_RVALID_WAIT (32),
    .ASSUME_MASK     (2'b00)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .req_i         (req_i),
    .gnt_i         (gnt_i),
    .rvalid_i      (rvalid_i),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .outstanding_o (outstanding_o),
    .err_o         (err_o),
    .err_code_o    (err_code_o),
    .err_any_o     (err_any_o)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [3:0]  be0;
    logic [3:0]  be1;
    logic [31:0] addr1;
    logic [7:0]  exp_out;
    logic [1:0]  exp_err;
    logic [7:0]  exp_code;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(logic rst_n, logic [1:0] req, logic [1:0] gnt, logic [1:0] rv,
                               logic [3:0] be0, logic [3:0] be1, logic [31:0] addr1,
                               logic [7:0] eo, logic [1:0] ee, logic [7:0] ec);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.gnt = gnt; v.rv = rv; v.be0 = be0; v.be1 = be1;
    v.addr1 = addr1; v.exp_out = eo; v.exp_err = ee; v.exp_code = ec;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx, input logic [7:0] eo,
                           input logic [1:0] ee, input logic [7:0] ec);
    check({name, ".outstanding"}, idx, 32'(outstanding_o), 32'(eo));
    check({name, ".err"},         idx, 32'(err_o),         32'(ee));
    check({name, ".err_code"},    idx, 32'(err_code_o),    32'(ec));
    check({name, ".err_any"},     idx, 32'(err_any_o),     32'(|ee));
  endtask

  // Drive one cycle of stimulus at the falling edge and sample 1 time unit after the rising edge.
  task automatic cyc(input logic rst_n, input logic en, input logic [1:0] req, input logic [1:0] gnt,
                     input logic [1:0] rv, input logic [3:0] be0, input logic [3:0] be1,
                     input logic [31:0] addr1);
    @(negedge clk_i);
    rst_ni   = rst_n;
    enable_i = en;
    req_i    = req;
    gnt_i    = gnt;
    rvalid_i = rv;
    we_i     = 2'b00;
    be_i     = {be1, be0};
    addr_i   = {addr1, 32'h0000_0000};
    wdata_i  = 64'h0;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni   = 1'b0;
    enable_i = 1'b1;
    req_i    = 2'b00;
    gnt_i    = 2'b00;
    rvalid_i = 2'b00;
    we_i     = 2'b00;
    addr_i   = 64'h0;
    be_i     = 8'hFF;
    wdata_i  = 64'h0;

    // Port 1: three wait cycles then grant, response two cycles later.
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b10, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b10, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b10, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b10, 2'b10, 2'b00, 4'hF, 4'hF, 32'h100, 8'h10, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h10, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b10, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    // Port 1: address changes in WAIT_GNT -> code 2, sticky through clean traffic.
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b10, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b10, 2'b00, 2'b00, 4'hF, 4'hF, 32'h104, 8'h00, 2'b10, 8'h20));
    vecs.push_back(row(1'b1, 2'b10, 2'b10, 2'b00, 4'hF, 4'hF, 32'h104, 8'h10, 2'b10, 8'h20));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b10, 4'hF, 4'hF, 32'h104, 8'h00, 2'b10, 8'h20));
    vecs.push_back(row(1'b1, 2'b10, 2'b10, 2'b00, 4'hF, 4'hF, 32'h200, 8'h10, 2'b10, 8'h20));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b10, 4'hF, 4'hF, 32'h200, 8'h00, 2'b10, 8'h20));
    // Port 0: third grant beyond MAX_OUTSTANDING -> code 4, counter still counts.
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100, 8'h01, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100, 8'h02, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100, 8'h03, 2'b01, 8'h04));
    // Same, with rvalid coincident on the third grant -> no error.
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100, 8'h01, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100, 8'h02, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b01, 4'hF, 4'hF, 32'h100, 8'h02, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b01, 4'hF, 4'hF, 32'h100, 8'h01, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b01, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    // Port 0: unsolicited rvalid -> code 3; with be==0 request too, 3 still wins.
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b01, 4'hF, 4'hF, 32'h100, 8'h00, 2'b01, 8'h03));
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b01, 4'h0, 4'hF, 32'h100, 8'h00, 2'b01, 8'h03));
    // Port 0: be==0 alone -> code 7.
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b01, 2'b01, 2'b00, 4'h0, 4'hF, 32'h100, 8'h01, 2'b01, 8'h07));
    // Port 1: req dropped in WAIT_GNT -> code 1.
    vecs.push_back(row(1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b10, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b00, 8'h00));
    vecs.push_back(row(1'b1, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100, 8'h00, 2'b10, 8'h10));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, 1'b1, vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].be0, vecs[i].be1, vecs[i].addr1);
      check_all("vec", i, vecs[i].exp_out, vecs[i].exp_err, vecs[i].exp_code);
    end

    // Gnt withheld: 16 cycles is legal, the 17th raises code 5.
    cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    check_all("gnt_wait_16", 0, 8'h00, 2'b00, 8'h00);
    cyc(1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    check_all("gnt_wait_17", 0, 8'h00, 2'b01, 8'h05);

    // Same with enable_i low: nothing flagged, late grant still counted.
    cyc(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    check_all("gnt_wait_dis", 0, 8'h00, 2'b00, 8'h00);
    cyc(1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100);
    check_all("gnt_late_ok", 0, 8'h01, 2'b00, 8'h00);

    // Rvalid withheld: 32 waiting cycles legal, the 33rd raises code 6.
    cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    cyc(1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100);
    for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    check_all("rv_wait_32", 0, 8'h01, 2'b00, 8'h00);
    cyc(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    check_all("rv_wait_33", 0, 8'h01, 2'b01, 8'h06);

    // Async reset with traffic outstanding and a code latched clears everything at once.
    cyc(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 4'hF, 4'hF, 32'h100);
    cyc(1'b1, 1'b1, 2'b11, 2'b11, 2'b00, 4'hF, 4'h0, 32'h100);
    check_all("pre_rst", 0, 8'h11, 2'b10, 8'h70);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all("async_rst", 0, 8'h00, 2'b00, 8'h00);
    cyc(1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 4'hF, 4'hF, 32'h100);
    check_all("post_rst_gnt", 0, 8'h01, 2'b00, 8'h00);
    cyc(1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 4'hF, 4'hF, 32'h100);
    check_all("post_rst_rv", 0, 8'h00, 2'b00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
